// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency FP multiplier
// datapath among N_REQ requesters, with a tagged response channel and
// per-requester sticky exception flags.

package rnd_enum;
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_t;
endpackage

module fp_mult_arbiter
  import rnd_enum::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  input  rnd_t [N_REQ-1:0]     req_rnd,
  output logic [31:0]          dp_a,
  output logic [31:0]          dp_b,
  output rnd_t                 dp_rnd,
  output logic                 dp_start,
  input  logic [31:0]          dp_z,
  input  logic [5:0]           dp_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_z,
  output logic [5:0]           rsp_flags,
  output logic [N_REQ*6-1:0]   sticky_flags,
  input  logic [N_REQ-1:0]     sticky_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt, id_r, gnt_idx;
  logic [IDW:0]   probe, rr_inc;
  logic           gnt_vld, hs, cap;
  logic [3:0]     cnt;
  logic [31:0]    a_arr [N_REQ];
  logic [31:0]    b_arr [N_REQ];
  logic [5:0]     sticky_r [N_REQ];

  // Unpack the flat operand buses into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[32*i +: 32];
      b_arr[i] = req_b[32*i +: 32];
    end
  end

  // Round-robin search from rr_ptr upward, wrapping modulo N_REQ
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      probe = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (probe >= NREQ_W) probe = probe - NREQ_W;
      if (!gnt_vld && req_valid[probe[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = probe[IDW-1:0];
      end
    end
    rr_inc = {1'b0, gnt_idx} + (IDW+1)'(1);
    rr_nxt = (rr_inc == NREQ_W) ? '0 : rr_inc[IDW-1:0];
  end

  assign hs  = |(req_valid & req_ready);
  assign cap = (state == WAIT) && (cnt == 4'd0);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (hs) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; req_ready is held low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_vld && !rst) req_ready[gnt_idx] = 1'b1;
    dp_start  = (state == ISSUE);
    rsp_valid = (state == RESP);
    rsp_id    = id_r;
  end

  // Operand latch, pointer, latency counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a      <= '0;
      dp_b      <= '0;
      dp_rnd    <= RNE;
      id_r      <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
    end else begin
      if (hs) begin
        dp_a   <= a_arr[gnt_idx];
        dp_b   <= b_arr[gnt_idx];
        dp_rnd <= req_rnd[gnt_idx];
        id_r   <= gnt_idx;
        rr_ptr <= rr_nxt;
      end
      if (state == ISSUE)                cnt <= 4'(LAT - 1);
      else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
      if (cap) begin
        rsp_z     <= dp_z;
        rsp_flags <= dp_flags;
      end
    end
  end

  // Sticky flags: a same-cycle update replaces the slice, otherwise clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) sticky_r[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (cap && id_r == IDW'(i))
          sticky_r[i] <= sticky_clr[i] ? dp_flags : (sticky_r[i] | dp_flags);
        else if (sticky_clr[i])
          sticky_r[i] <= '0;
      end
    end
  end

  // Flatten sticky slices onto the output bus
  always_comb begin
    sticky_flags = '0;
    for (int unsigned i = 0; i < N_REQ; i++) sticky_flags[6*i +: 6] = sticky_r[i];
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: directed vector table, hand-written
// corner sequences and a randomized phase against a transaction-level model.

module tb_fp_mult_arbiter;
  import rnd_enum::*;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, sticky_clr;
  logic [N*32-1:0] req_a, req_b;
  rnd_t [N-1:0]  req_rnd;
  logic [31:0]   dp_a, dp_b, dp_z, rsp_z;
  rnd_t          dp_rnd;
  logic          dp_start, rsp_valid, rsp_ready;
  logic [5:0]    dp_flags, rsp_flags;
  logic [1:0]    rsp_id;
  logic [N*6-1:0] sticky_flags;

  // Second instance: three requesters, non-power-of-two wrap
  logic [2:0]    req_valid3, req_ready3;
  logic [95:0]   req_a3, req_b3;
  rnd_t [2:0]    req_rnd3;
  logic [31:0]   dp_a3, dp_b3, rsp_z3;
  rnd_t          dp_rnd3;
  logic          dp_start3, rsp_valid3;
  logic [1:0]    rsp_id3;
  logic [5:0]    rsp_flags3;
  logic [17:0]   sticky_flags3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .dp_a(dp_a), .dp_b(dp_b), .dp_rnd(dp_rnd), .dp_start(dp_start),
    .dp_z(dp_z), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr));

  fp_mult_arbiter #(.N_REQ(3), .LAT(1)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_rnd(req_rnd3),
    .dp_a(dp_a3), .dp_b(dp_b3), .dp_rnd(dp_rnd3), .dp_start(dp_start3),
    .dp_z(dp_a3), .dp_flags(6'd0),
    .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_id(rsp_id3),
    .rsp_z(rsp_z3), .rsp_flags(rsp_flags3),
    .sticky_flags(sticky_flags3), .sticky_clr(3'b000));

  // Datapath stand-in: result is only valid exactly LAT cycles after dp_start
  function automatic logic [31:0] mz(input logic [31:0] a, b, input logic [2:0] r);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ b ^ {29'd0, r};
  endfunction
  function automatic logic [5:0] mf(input logic [31:0] a, b);
    return a[5:0] ^ b[5:0];
  endfunction

  int age;
  always @(posedge clk or posedge rst) begin
    if (rst)                      age <= 0;
    else if (dp_start)            age <= 1;
    else if (age != 0 && age < LAT) age <= age + 1;
    else                          age <= 0;
  end
  assign dp_z     = (age == LAT) ? mz(dp_a, dp_b, dp_rnd) : 32'hDEAD_BEEF;
  assign dp_flags = (age == LAT) ? mf(dp_a, dp_b) : 6'h2A;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sticky model kept per requester
  logic [5:0] sm [N];
  function automatic logic [N*6-1:0] sm_pack();
    logic [N*6-1:0] v;
    for (int i = 0; i < N; i++) v[6*i +: 6] = sm[i];
    return v;
  endfunction

  // Reference round-robin choice from the specification's rule
  function automatic int ref_arb(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] a, b;
    logic [2:0]  rnd;
    logic [31:0] ez;
    logic [5:0]  ef;
  } vec_t;

  // One operation with cycle-exact checks; bp>0 holds rsp_ready low
  task automatic do_op(input int id, input logic [31:0] a, b, input logic [2:0] rnd,
                       input logic [31:0] ez, input logic [5:0] ef,
                       input bit clr, input int bp);
    bit got;
    @(negedge clk);
    req_valid = '0; req_valid[id] = 1'b1;
    req_a[32*id +: 32] = a; req_b[32*id +: 32] = b; req_rnd[id] = rnd_t'(rnd);
    #1;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (req_ready != 0) got = 1;
      else begin @(negedge clk); #1; end
    end
    chk("grant", {60'd0, req_ready}, 64'(1 << id));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("dp_start", {63'd0, dp_start}, 64'd1);
    chk("dp_ops", {dp_a, dp_b}, {a, b});
    chk("dp_rnd", {61'd0, dp_rnd}, {61'd0, rnd});
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (clr && i == LAT) sticky_clr[id] = 1'b1;
      #1;
      chk("wait_quiet", {62'd0, dp_start, rsp_valid}, 64'd0);
    end
    sm[id] = clr ? ef : (sm[id] | ef);
    @(negedge clk);
    sticky_clr = '0;
    rsp_ready = (bp == 0);
    if (bp > 0) req_valid = '1;
    #1;
    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rsp_fields", {24'd0, rsp_id, rsp_flags, rsp_z}, {24'd0, 2'(id), ef, ez});
    chk("sticky", {40'd0, sticky_flags}, {40'd0, sm_pack()});
    if (bp > 0) begin
      for (int j = 0; j < bp; j++) begin
        @(negedge clk); #1;
        chk("bp_hold", {20'd0, rsp_valid, dp_start, req_ready, rsp_id, rsp_flags, rsp_z},
            {20'd0, 1'b1, 1'b0, 4'd0, 2'(id), ef, ez});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("bp_last", {63'd0, rsp_valid}, 64'd1);
      @(negedge clk); #1;
      chk("bp_next_grant", {60'd0, req_ready}, 64'(1 << ((id + 1) % N)));
      req_valid = '0;
    end else begin
      @(negedge clk); #1;
      chk("rsp_done", {63'd0, rsp_valid}, 64'd0);
    end
  endtask

  // Randomized phase state
  typedef struct { int id; logic [31:0] z; logic [5:0] f; } exp_t;
  exp_t sbq[$];
  int   ref_ptr, cyc, gcyc, grants;
  bit   busy, rsp_seen;

  task automatic mon_cycle(input bit stim);
    exp_t e;
    int   g, p;
    @(negedge clk);
    cyc++;
    if (stim) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 1) == 1);
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
        req_rnd[i] = rnd_t'($urandom_range(0, 4));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      req_valid = '0;
      rsp_ready = 1'b1;
    end
    #1;
    if (rsp_valid && !rsp_seen) begin
      rsp_seen = 1;
      chk("rnd_latency", 64'(cyc - gcyc), 64'(LAT + 2));
    end
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) chk("rnd_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("rnd_rsp", {24'd0, rsp_id, rsp_flags, rsp_z}, {24'd0, 2'(e.id), e.f, e.z});
        sm[e.id] = sm[e.id] | e.f;
      end
      busy = 0;
    end else if (busy) begin
      chk("rnd_busy_ready", {60'd0, req_ready}, 64'd0);
    end else begin
      p = ref_arb(req_valid, ref_ptr);
      if (p < 0) chk("rnd_idle_ready", {60'd0, req_ready}, 64'd0);
      else begin
        chk("rnd_grant", {60'd0, req_ready}, 64'(1 << p));
        g = p;
        e.id = g;
        e.z  = mz(req_a[32*g +: 32], req_b[32*g +: 32], req_rnd[g]);
        e.f  = mf(req_a[32*g +: 32], req_b[32*g +: 32]);
        sbq.push_back(e);
        ref_ptr = (g + 1) % N;
        busy = 1; rsp_seen = 0; gcyc = cyc; grants++;
      end
    end
  endtask

  vec_t vt [5];
  int   gid [5];
  int   gt  [5];
  int   ng, t;
  bit   got;

  initial begin
    vt[0] = '{1, 32'h4000_0000, 32'h4040_0000, 3'd0, 32'h40C0_0000, 6'b000000};
    vt[1] = '{2, 32'h0000_0008, 32'h0000_0000, 3'd0, 32'h0000_0008, 6'b001000};
    vt[2] = '{2, 32'h0000_0001, 32'h0000_0000, 3'd1, 32'h0000_0000, 6'b000001};
    vt[3] = '{0, 32'h1234_5678, 32'h0000_FFFF, 3'd2, 32'h1234_A985, 6'b000111};
    vt[4] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 32'h0000_0004, 6'b000000};
    for (int i = 0; i < N; i++) sm[i] = '0;

    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; req_rnd = '{default: RNE};
    sticky_clr = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_rnd3 = '{default: RNE};
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {dp_a, 22'd0, req_ready, dp_start, rsp_valid, rsp_id, rsp_flags},
        64'd0);
    chk("reset_sticky", {40'd0, sticky_flags}, 64'd0);

    // All four requesters valid continuously from reset
    @(negedge clk);
    rst = 1'b0;
    ng = 0; t = 0;
    while (ng < 5 && t < 60) begin
      #1;
      if (req_ready != 0) begin
        gid[ng] = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) gid[ng] = i;
        gt[ng] = t;
        ng++;
      end
      @(negedge clk);
      t++;
    end
    chk("rr_count", 64'(ng), 64'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(gid[i]), 64'(i % N));
    for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(gt[i] - gt[i-1]), 64'(LAT + 3));
    req_valid = '0;
    repeat (LAT + 4) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      do_op(vt[i].id, vt[i].a, vt[i].b, vt[i].rnd, vt[i].ez, vt[i].ef, 1'b0, 0);
      if (i == 2) chk("sticky2_nan_inexact", {58'd0, sticky_flags[17:12]}, 64'b001001);
    end
    // Clear in the capture cycle of a huge result: update wins
    do_op(2, 32'h0000_0004, 32'h0, 3'd0, 32'h0000_0004, 6'b000100, 1'b1, 0);
    chk("sticky2_clr_update", {58'd0, sticky_flags[17:12]}, 64'b000100);
    // Plain clear of a different slice
    @(negedge clk); sticky_clr = 4'b0001; sm[0] = '0;
    @(negedge clk); sticky_clr = '0; #1;
    chk("sticky_clr0", {40'd0, sticky_flags}, {40'd0, sm_pack()});
    // Backpressure
    do_op(0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'd3, 32'hAAAA_AAA9, 6'b101010, 1'b0, 5);

    // Async reset during WAIT
    @(negedge clk);
    req_valid = 4'b1000; #1;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (req_ready != 0) got = 1; else begin @(negedge clk); #1; end
    end
    chk("rst_grant", {60'd0, req_ready}, 64'b1000);
    @(negedge clk); req_valid = '0;
    @(negedge clk); req_valid = '1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", {dp_a, 22'd0, req_ready, dp_start, rsp_valid, rsp_id, rsp_flags},
        64'd0);
    chk("rst_async_sticky", {40'd0, sticky_flags, rsp_z}, 64'd0);
    for (int i = 0; i < N; i++) sm[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_next_grant", {60'd0, req_ready}, 64'b0001);
    req_valid = '0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk); #1;
      chk("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end

    // Randomized traffic against the transaction model
    ref_ptr = 0; busy = 0; rsp_seen = 1; cyc = 0; gcyc = 0; grants = 0;
    for (int i = 0; i < 400; i++) mon_cycle(1'b1);
    for (int i = 0; i < 20; i++) mon_cycle(1'b0);
    chk("rnd_drained", {31'd0, busy, 32'(sbq.size())}, 64'd0);
    chk("rnd_sticky", {40'd0, sticky_flags}, {40'd0, sm_pack()});
    tests++;
    if (grants < 10) begin
      fails++;
      $display("FAIL rnd_grants: got %0d expected at least 10", grants);
    end

    // Three requesters: pointer to 2, then 2 and 0 valid
    @(negedge clk);
    req_valid3 = 3'b010; #1;
    chk("n3_first", {61'd0, req_ready3}, 64'b010);
    @(negedge clk); req_valid3 = '0;
    repeat (6) @(negedge clk);
    req_valid3 = 3'b101; #1;
    chk("n3_grant2", {61'd0, req_ready3}, 64'b100);
    @(negedge clk); #1;
    got = 0;
    for (int w = 0; w < 12 && !got; w++) begin
      if (req_ready3 != 0) got = 1; else begin @(negedge clk); #1; end
    end
    chk("n3_wrap0", {61'd0, req_ready3}, 64'b001);
    @(negedge clk); req_valid3 = '0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
